// File: rtl/uart_burst_mem_access.sv
// UART byte-stream to flat register-file bridge: burst reads/writes with address wrap and inter-byte timeout.
// Optional feature macro UART_BURST_MEM_CHECKSUM_EN: return an 8-bit data checksum (writes and reads).
module uart_burst_mem_access #(
  parameter int unsigned AddrWidth     = 7,
  parameter int unsigned AddrBytes     = (AddrWidth + 7) / 8,
  parameter int unsigned TimeoutCycles = 1000000,
  parameter logic [7:0]  AckByte       = 8'hA5
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  output logic                        o_rx_ready,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  output logic [8*(2**AddrWidth)-1:0] o_wmem,
  input  logic [8*(2**AddrWidth)-1:0] i_rmem,
  output logic                        o_busy,
  output logic                        o_timeout
);

  localparam int unsigned TmoWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned AbWidth  = (AddrBytes > 1) ? $clog2(AddrBytes) : 1;
  localparam bit          TmoEn    = (TimeoutCycles != 0);
  localparam logic [TmoWidth-1:0] TmoLast =
    TmoWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
  localparam logic [AbWidth-1:0] AbLast = AbWidth'(AddrBytes - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RLOAD,
    S_RSEND,
    S_ACK
`ifdef UART_BURST_MEM_CHECKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  state_t                state, state_d;
  logic                  rd_wrn;
  logic [6:0]            len_cnt;
  logic [AbWidth-1:0]    ab_cnt;
  logic [AddrWidth-1:0]  addr;
  logic [TmoWidth-1:0]   tmo_cnt;
  logic                  in_frame, tmo_fire, rx_acc, tx_acc, len_last;
`ifdef UART_BURST_MEM_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  // The timeout beats a byte arriving in the same cycle by withholding ready.
  assign in_frame   = (state == S_ADDR) || (state == S_WDATA);
  assign tmo_fire   = TmoEn && in_frame && (tmo_cnt == TmoLast);
  assign o_rx_ready = ((state == S_IDLE) || in_frame) && !tmo_fire;
  assign rx_acc     = i_rx_valid && o_rx_ready;
  assign tx_acc     = o_tx_valid && i_tx_ready;
  assign len_last   = (len_cnt == '0);
  assign o_busy     = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (rx_acc) state_d = S_ADDR;
      S_ADDR: begin
        if (tmo_fire)                         state_d = S_IDLE;
        else if (rx_acc && (ab_cnt == AbLast)) state_d = rd_wrn ? S_RLOAD : S_WDATA;
      end
      S_WDATA: begin
        if (tmo_fire)              state_d = S_IDLE;
        else if (rx_acc && len_last) state_d = S_ACK;
      end
      S_RLOAD: state_d = S_RSEND;
      S_RSEND: begin
        if (tx_acc) begin
`ifdef UART_BURST_MEM_CHECKSUM_EN
          state_d = len_last ? S_CKSUM : S_RLOAD;
`else
          state_d = len_last ? S_IDLE : S_RLOAD;
`endif
        end
      end
      S_ACK:   if (tx_acc) state_d = S_IDLE;
`ifdef UART_BURST_MEM_CHECKSUM_EN
      S_CKSUM: if (tx_acc) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: frame header capture, memory writes, tx byte staging and timeout counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_wrn     <= 1'b0;
      len_cnt    <= '0;
      ab_cnt     <= '0;
      addr       <= '0;
      tmo_cnt    <= '0;
      o_wmem     <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_timeout  <= 1'b0;
`ifdef UART_BURST_MEM_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      o_timeout <= tmo_fire;
      if (TmoEn && in_frame && !rx_acc && !tmo_fire) tmo_cnt <= tmo_cnt + 1'b1;
      else                                           tmo_cnt <= '0;
      case (state)
        S_IDLE: if (rx_acc) begin
          rd_wrn  <= i_rx_data[7];
          len_cnt <= i_rx_data[6:0];
          ab_cnt  <= '0;
`ifdef UART_BURST_MEM_CHECKSUM_EN
          csum    <= '0;
`endif
        end
        S_ADDR: if (rx_acc) begin
          addr   <= AddrWidth'({addr, i_rx_data});
          ab_cnt <= ab_cnt + 1'b1;
        end
        S_WDATA: if (rx_acc) begin
          o_wmem[8*addr +: 8] <= i_rx_data;
          addr    <= addr + 1'b1;
          len_cnt <= len_cnt - 1'b1;
`ifdef UART_BURST_MEM_CHECKSUM_EN
          csum    <= csum + i_rx_data;
          if (len_last) o_tx_data <= csum + i_rx_data;
`else
          if (len_last) o_tx_data <= AckByte;
`endif
          if (len_last) o_tx_valid <= 1'b1;
        end
        S_RLOAD: begin
          o_tx_data  <= i_rmem[8*addr +: 8];
          o_tx_valid <= 1'b1;
        end
        S_RSEND: if (tx_acc) begin
          o_tx_valid <= 1'b0;
          addr       <= addr + 1'b1;
          len_cnt    <= len_cnt - 1'b1;
`ifdef UART_BURST_MEM_CHECKSUM_EN
          csum       <= csum + o_tx_data;
          if (len_last) begin
            o_tx_data  <= csum + o_tx_data;
            o_tx_valid <= 1'b1;
          end
`endif
        end
        default: if (tx_acc) o_tx_valid <= 1'b0;
      endcase
    end
  end

endmodule
